// File: rtl/joystick_serial_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : joystick_serial_reader_pkg
//  Description : Shared types and constants for the 74HC165 joystick reader:
//                scan FSM states, chain bit positions and output slot layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package joystick_serial_reader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int NUM_CHAIN_BITS = 16;
    localparam int BIT_IDX_W      = $clog2(NUM_CHAIN_BITS);
    localparam int JOY_W          = 5;
    localparam int NUM_BUTTONS    = 2 * JOY_W;

    // Position of each button in the chain, in shift order
    localparam logic [BIT_IDX_W-1:0] UP1    = BIT_IDX_W'(0);
    localparam logic [BIT_IDX_W-1:0] DOWN1  = BIT_IDX_W'(1);
    localparam logic [BIT_IDX_W-1:0] LEFT1  = BIT_IDX_W'(2);
    localparam logic [BIT_IDX_W-1:0] RIGHT1 = BIT_IDX_W'(3);
    localparam logic [BIT_IDX_W-1:0] FIRE1  = BIT_IDX_W'(4);
    localparam logic [BIT_IDX_W-1:0] UP2    = BIT_IDX_W'(8);
    localparam logic [BIT_IDX_W-1:0] DOWN2  = BIT_IDX_W'(9);
    localparam logic [BIT_IDX_W-1:0] LEFT2  = BIT_IDX_W'(10);
    localparam logic [BIT_IDX_W-1:0] RIGHT2 = BIT_IDX_W'(11);
    localparam logic [BIT_IDX_W-1:0] FIRE2  = BIT_IDX_W'(12);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(NUM_CHAIN_BITS - 1);

    // Slot of each button inside a 5-bit {fire,up,down,left,right} vector
    localparam int FIRE_SLOT  = 4;
    localparam int UP_SLOT    = 3;
    localparam int DOWN_SLOT  = 2;
    localparam int LEFT_SLOT  = 1;
    localparam int RIGHT_SLOT = 0;

endpackage
`default_nettype wire

// File: rtl/joystick_serial_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : joystick_serial_reader_if
//  Description : Bundle of the reader's control, chain and joystick signals.
//                master = reader side, slave = chain/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface joystick_serial_reader_if;

    logic                                     enable;
    logic                                     joy_data;
    logic                                     joy_load_n;
    logic                                     joy_clk;
    logic [joystick_serial_reader_pkg::JOY_W-1:0] joy1_out;
    logic [joystick_serial_reader_pkg::JOY_W-1:0] joy2_out;
    logic                                     scan_done;

    modport master (
        input  enable,
        input  joy_data,
        output joy_load_n,
        output joy_clk,
        output joy1_out,
        output joy2_out,
        output scan_done
    );

    modport slave (
        output enable,
        output joy_data,
        input  joy_load_n,
        input  joy_clk,
        input  joy1_out,
        input  joy2_out,
        input  scan_done
    );

endinterface
`default_nettype wire

// File: rtl/joystick_serial_reader_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : joy_debounce
//  Description : Single-button debouncer. The output flips only after the raw
//                bit has differed from it on DEBOUNCE consecutive updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_debounce #(
    parameter int DEBOUNCE = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic update,
    input  wire logic raw,
    output logic      debounced
);

    localparam int                c_cnt_w = $clog2(DEBOUNCE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_out;

    // Count consecutive disagreeing updates; commit the raw value on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b1;
        end else if (update) begin
            if (raw == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_out <= raw;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign debounced = r_out;

endmodule
`default_nettype wire

// File: rtl/joystick_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module      : joystick_serial_reader
//  Description : Scans a 16-bit 74HC165 dual-joystick chain, synchronises the
//                serial data and presents two debounced active-low FUDLR
//                vectors plus a one-cycle scan_done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module joystick_serial_reader
    import joystick_serial_reader_pkg::*;
#(
    parameter int CLKDIV   = 4,
    parameter int DEBOUNCE = 8
) (
    input wire logic                  clk,
    input wire logic                  rst,
    joystick_serial_reader_if.master  bus
);

    localparam int                 c_div_w    = $clog2(CLKDIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKDIV - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_div_w-1:0]     r_div;
    logic [c_div_w-1:0]     w_div_next;
    logic [BIT_IDX_W-1:0]   r_bit;
    logic [BIT_IDX_W-1:0]   w_bit_next;
    logic                   w_div_last;
    logic                   w_sample;

    logic                   r_sync_meta;
    logic                   r_sync;
    logic [NUM_BUTTONS-1:0] r_raw;
    logic [NUM_BUTTONS-1:0] w_debounced;

    logic                   r_load_n;
    logic                   r_joy_clk;
    logic                   r_scan_done;

    assign w_div_last = (r_div == c_div_last);

    // Two-flop synchroniser for the asynchronous chain output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= bus.joy_data;
            r_sync      <= r_sync_meta;
        end
    end

    // Next-state logic: each phase lasts CLKDIV cycles, DONE lasts one
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_next = '0;
                w_bit_next = '0;
                if (bus.enable) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_div_last) begin
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = LOW;
                end else begin
                    w_div_next = r_div + c_div_w'(1);
                end
            end
            LOW: begin
                if (w_div_last) begin
                    w_sample     = 1'b1;
                    w_div_next   = '0;
                    w_state_next = (r_bit == LAST_BIT) ? DONE : HIGH;
                end else begin
                    w_div_next = r_div + c_div_w'(1);
                end
            end
            HIGH: begin
                if (w_div_last) begin
                    w_div_next   = '0;
                    w_bit_next   = r_bit + BIT_IDX_W'(1);
                    w_state_next = LOW;
                end else begin
                    w_div_next = r_div + c_div_w'(1);
                end
            end
            DONE: begin
                w_div_next   = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_div_next   = '0;
                w_bit_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State register; chain strobes are registered from the next state so
    // they stay glitch-free and line up exactly with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_load_n    <= 1'b1;
            r_joy_clk   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_bit       <= w_bit_next;
            r_load_n    <= (w_state_next != LOAD);
            r_joy_clk   <= (w_state_next == HIGH);
            r_scan_done <= (w_state_next == DONE);
        end
    end

    // Capture mapped chain bits straight into FUDLR slots; unused bits are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw <= '1;
        end else if (w_sample) begin
            case (r_bit)
                UP1:     r_raw[UP_SLOT]            <= r_sync;
                DOWN1:   r_raw[DOWN_SLOT]          <= r_sync;
                LEFT1:   r_raw[LEFT_SLOT]          <= r_sync;
                RIGHT1:  r_raw[RIGHT_SLOT]         <= r_sync;
                FIRE1:   r_raw[FIRE_SLOT]          <= r_sync;
                UP2:     r_raw[JOY_W + UP_SLOT]    <= r_sync;
                DOWN2:   r_raw[JOY_W + DOWN_SLOT]  <= r_sync;
                LEFT2:   r_raw[JOY_W + LEFT_SLOT]  <= r_sync;
                RIGHT2:  r_raw[JOY_W + RIGHT_SLOT] <= r_sync;
                FIRE2:   r_raw[JOY_W + FIRE_SLOT]  <= r_sync;
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_debounce
            joy_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_debounce (
                .clk       (clk),
                .rst       (rst),
                .update    (r_state == DONE),
                .raw       (r_raw[gi]),
                .debounced (w_debounced[gi])
            );
        end
    endgenerate

    assign bus.joy_load_n = r_load_n;
    assign bus.joy_clk    = r_joy_clk;
    assign bus.scan_done  = r_scan_done;
    assign bus.joy1_out   = w_debounced[JOY_W-1:0];
    assign bus.joy2_out   = w_debounced[NUM_BUTTONS-1:JOY_W];

endmodule
`default_nettype wire
